// File: rtl/memory_stage_mc.sv
// memory_stage_mc: execute->writeback memory stage with a valid/ready data-memory port.
// Latency: non-memory ops and misaligned accesses 1 cycle; memory ops >= 3 cycles (req, resp, output).
// Backpressure: in_ready_o drops while an access is in flight or the output is stalled; flush drains.
// Ports: clk_i/rst_i (async, active-low); flush_v_i/stall_v_i/stall_v_o pipeline control;
//   in_* instruction from execute; out_* writeback word; dmem_req_*/dmem_resp_* memory interface.
module memory_stage_mc #(
  parameter int xlen_p          = 32,
  parameter int payload_width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_v_i,
  input  logic                       stall_v_i,
  output logic                       stall_v_o,
  input  logic                       in_v_i,
  output logic                       in_ready_o,
  input  logic                       in_ld_v_i,
  input  logic                       in_st_v_i,
  input  logic [2:0]                 in_funct3_i,
  input  logic [xlen_p-1:0]          in_addr_i,
  input  logic [xlen_p-1:0]          in_st_data_i,
  input  logic [4:0]                 in_rd_i,
  input  logic                       in_rd_w_v_i,
  input  logic [payload_width_p-1:0] in_payload_i,
  output logic                       out_v_o,
  output logic [xlen_p-1:0]          out_result_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_rd_w_v_o,
  output logic [payload_width_p-1:0] out_payload_o,
  output logic                       out_misalign_o,
  output logic                       out_err_o,
  output logic                       dmem_req_v_o,
  input  logic                       dmem_req_ready_i,
  output logic                       dmem_we_o,
  output logic [xlen_p-1:0]          dmem_addr_o,
  output logic [xlen_p/8-1:0]        dmem_be_o,
  output logic [xlen_p-1:0]          dmem_wdata_o,
  input  logic                       dmem_resp_v_i,
  input  logic                       dmem_resp_err_i,
  input  logic [xlen_p-1:0]          dmem_rdata_i
);
  localparam int nb_lp = xlen_p / 8;
  localparam int lw_lp = $clog2(nb_lp);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;
  state_e state_q, state_d;

  // Latched access (stable for the whole REQ/WAIT window)
  logic                       we_q, uns_q, rd_w_v_q;
  logic [1:0]                 size_q;
  logic [lw_lp-1:0]           lane_q;
  logic [4:0]                 rd_q;
  logic [payload_width_p-1:0] payload_q;
  logic [xlen_p-1:0]          addr_q, wdata_q;
  logic [nb_lp-1:0]           be_q;
  logic                       capture;

  // Output register
  logic                       out_v_q, out_v_d;
  logic [xlen_p-1:0]          out_result_q, out_result_d;
  logic [4:0]                 out_rd_q, out_rd_d;
  logic                       out_rd_w_v_q, out_rd_w_v_d;
  logic [payload_width_p-1:0] out_payload_q, out_payload_d;
  logic                       out_misalign_q, out_misalign_d;
  logic                       out_err_q, out_err_d;

  // Decode of the incoming instruction
  logic               mem_op, misalign;
  logic [1:0]         size_d;
  logic [lw_lp-1:0]   lane_d;
  logic [nb_lp-1:0]   be_d;
  logic [xlen_p-1:0]  addr_d, wdata_d;

  always_comb begin
    mem_op = in_ld_v_i | in_st_v_i;
    size_d = in_funct3_i[1:0];
    // RV32 has no doubleword: LD behaves as LW.
    if (xlen_p == 32 && size_d == 2'd3) size_d = 2'd2;
    lane_d = in_addr_i[lw_lp-1:0];
    addr_d = {in_addr_i[xlen_p-1:lw_lp], lw_lp'(0)};
    case (size_d)
      2'd0: begin
        misalign = 1'b0;
        be_d     = nb_lp'(1) << lane_d;
        wdata_d  = {nb_lp{in_st_data_i[7:0]}};
      end
      2'd1: begin
        misalign = in_addr_i[0];
        be_d     = nb_lp'(3) << lane_d;
        wdata_d  = {(xlen_p/16){in_st_data_i[15:0]}};
      end
      2'd2: begin
        misalign = |in_addr_i[1:0];
        be_d     = nb_lp'(15) << lane_d;
        wdata_d  = {(xlen_p/32){in_st_data_i[31:0]}};
      end
      default: begin
        misalign = |in_addr_i[2:0];
        be_d     = '1;
        wdata_d  = in_st_data_i;
      end
    endcase
  end

  // Load data: shift the addressed lane down, then fill above the access size.
  logic [xlen_p-1:0] ld_shift, ld_ext;
  logic              sign_bit;
  int                ld_bits;

  always_comb begin
    ld_shift = dmem_rdata_i >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = ld_shift[7];
      2'd1:    sign_bit = ld_shift[15];
      2'd2:    sign_bit = ld_shift[31];
      default: sign_bit = ld_shift[xlen_p-1];
    endcase
    sign_bit = sign_bit & ~uns_q;
    ld_bits  = 8 << size_q;
    ld_ext   = ld_shift;
    for (int i = 0; i < xlen_p; i++) begin
      if (i >= ld_bits) ld_ext[i] = sign_bit;
    end
  end

  logic hold, accept;
  assign hold       = out_v_q & stall_v_i;
  assign in_ready_o = (state_q == IDLE) & ~hold;
  assign stall_v_o  = in_v_i & ~in_ready_o;
  // A flush cycle never admits a new instruction.
  assign accept     = in_v_i & in_ready_o & ~flush_v_i;

  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    out_v_d        = out_v_q;
    out_result_d   = out_result_q;
    out_rd_d       = out_rd_q;
    out_rd_w_v_d   = out_rd_w_v_q;
    out_payload_d  = out_payload_q;
    out_misalign_d = out_misalign_q;
    out_err_d      = out_err_q;

    if (flush_v_i || !hold) begin
      out_v_d        = 1'b0;
      out_misalign_d = 1'b0;
      out_err_d      = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!mem_op || misalign) begin
            // Pass-through result, or misaligned exception with no bus traffic.
            out_v_d        = 1'b1;
            out_result_d   = in_addr_i;
            out_rd_d       = in_rd_i;
            out_rd_w_v_d   = in_rd_w_v_i & ~mem_op;
            out_payload_d  = in_payload_i;
            out_misalign_d = mem_op;
            out_err_d      = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (flush_v_i)             state_d = IDLE;
        else if (dmem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (flush_v_i) begin
          // The request was accepted, so its response must still be swallowed.
          state_d = dmem_resp_v_i ? IDLE : DRAIN;
        end else if (dmem_resp_v_i) begin
          state_d        = IDLE;
          out_v_d        = 1'b1;
          out_result_d   = we_q ? '0 : ld_ext;
          out_rd_d       = rd_q;
          out_rd_w_v_d   = rd_w_v_q & ~dmem_resp_err_i;
          out_payload_d  = payload_q;
          out_misalign_d = 1'b0;
          out_err_d      = dmem_resp_err_i;
        end
      end
      DRAIN: begin
        if (dmem_resp_v_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      rd_w_v_q       <= 1'b0;
      size_q         <= 2'd0;
      lane_q         <= '0;
      rd_q           <= '0;
      payload_q      <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      out_v_q        <= 1'b0;
      out_result_q   <= '0;
      out_rd_q       <= '0;
      out_rd_w_v_q   <= 1'b0;
      out_payload_q  <= '0;
      out_misalign_q <= 1'b0;
      out_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_v_q        <= out_v_d;
      out_result_q   <= out_result_d;
      out_rd_q       <= out_rd_d;
      out_rd_w_v_q   <= out_rd_w_v_d;
      out_payload_q  <= out_payload_d;
      out_misalign_q <= out_misalign_d;
      out_err_q      <= out_err_d;
      if (capture) begin
        we_q      <= in_st_v_i;
        uns_q     <= in_funct3_i[2];
        rd_w_v_q  <= in_rd_w_v_i;
        size_q    <= size_d;
        lane_q    <= lane_d;
        rd_q      <= in_rd_i;
        payload_q <= in_payload_i;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        be_q      <= be_d;
      end
    end
  end

  // Flush withdraws the request combinationally so a same-cycle ready is ignored.
  assign dmem_req_v_o   = (state_q == REQ) & ~flush_v_i;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;

  assign out_v_o        = out_v_q;
  assign out_result_o   = out_result_q;
  assign out_rd_o       = out_rd_q;
  assign out_rd_w_v_o   = out_rd_w_v_q;
  assign out_payload_o  = out_payload_q;
  assign out_misalign_o = out_misalign_q;
  assign out_err_o      = out_err_q;
endmodule

// File: tb/tb_memory_stage_mc.sv
// tb_memory_stage_mc: table vectors, corner-case sequences and random ops against a reference model.
// Latency: n/a (testbench).
// Backpressure: drives stall/flush/ready explicitly per sequence.
module tb_memory_stage_mc;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_v_i, stall_v_i, stall_v_o;
  logic        in_v_i, in_ready_o, in_ld_v_i, in_st_v_i;
  logic [2:0]  in_funct3_i;
  logic [31:0] in_addr_i, in_st_data_i;
  logic [4:0]  in_rd_i;
  logic        in_rd_w_v_i;
  logic [63:0] in_payload_i;
  logic        out_v_o;
  logic [31:0] out_result_o;
  logic [4:0]  out_rd_o;
  logic        out_rd_w_v_o;
  logic [63:0] out_payload_o;
  logic        out_misalign_o, out_err_o;
  logic        dmem_req_v_o, dmem_req_ready_i, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_resp_v_i, dmem_resp_err_i;
  logic [31:0] dmem_rdata_i;

  always #5 clk_i = ~clk_i;

  memory_stage_mc #(.xlen_p(32), .payload_width_p(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_v_i(flush_v_i), .stall_v_i(stall_v_i),
    .stall_v_o(stall_v_o), .in_v_i(in_v_i), .in_ready_o(in_ready_o),
    .in_ld_v_i(in_ld_v_i), .in_st_v_i(in_st_v_i), .in_funct3_i(in_funct3_i),
    .in_addr_i(in_addr_i), .in_st_data_i(in_st_data_i), .in_rd_i(in_rd_i),
    .in_rd_w_v_i(in_rd_w_v_i), .in_payload_i(in_payload_i),
    .out_v_o(out_v_o), .out_result_o(out_result_o), .out_rd_o(out_rd_o),
    .out_rd_w_v_o(out_rd_w_v_o), .out_payload_o(out_payload_o),
    .out_misalign_o(out_misalign_o), .out_err_o(out_err_o),
    .dmem_req_v_o(dmem_req_v_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_resp_v_i(dmem_resp_v_i),
    .dmem_resp_err_i(dmem_resp_err_i), .dmem_rdata_i(dmem_rdata_i)
  );

  typedef struct {
    logic ld; logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] sdata;
    logic [4:0] rd; logic rdw;
  } op_t;
  typedef struct {
    logic [31:0] res; logic rdw; logic mis; logic err; logic req;
    logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int lat;
  } exp_t;
  typedef struct {
    op_t op; logic [31:0] rdata; logic rerr; int rdy; int rsp; exp_t e;
  } vec_t;
  typedef struct {
    logic acc; logic done; int lat; logic [31:0] res; logic rdw; logic mis; logic err;
    logic [4:0] rd; logic [63:0] pay; logic req; logic unstable;
    logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;
  } obs_t;

  int n_vec = 0;
  int n_mis = 0;
  vec_t tbl [12];
  logic [2:0] ld_f3s [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  function automatic op_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] addr,
                             logic [31:0] sdata, logic [4:0] rd, logic rdw);
    op_t o;
    o.ld = ld; o.st = st; o.f3 = f3; o.addr = addr; o.sdata = sdata; o.rd = rd; o.rdw = rdw;
    return o;
  endfunction

  task automatic set_op(input op_t op);
    in_ld_v_i = op.ld; in_st_v_i = op.st; in_funct3_i = op.f3; in_addr_i = op.addr;
    in_st_data_i = op.sdata; in_rd_i = op.rd; in_rd_w_v_i = op.rdw;
    in_payload_i = {op.addr, ~op.addr};
  endtask

  // Reference: access size in bytes from funct3, natural alignment, lane arithmetic.
  function automatic exp_t model(op_t op, logic [31:0] rdata, logic rerr, int rdy, int rsp);
    exp_t e;
    int size, lane;
    logic [31:0] mask, v;
    e = '{default: 0};
    size = 1 << (op.f3 % 4);
    if (size > 4) size = 4;
    lane = int'(op.addr % 4);
    e.lat = 1;
    if (!(op.ld || op.st)) begin
      e.res = op.addr; e.rdw = op.rdw;
    end else if (op.addr % size != 0) begin
      e.mis = 1'b1; e.rdw = 1'b0;
    end else begin
      e.req  = 1'b1;
      e.addr = op.addr - lane;
      e.lat  = 3 + rdy + rsp;
      e.err  = rerr;
      e.rdw  = op.rdw && !rerr;
      if (op.st) begin
        e.be = 4'(((1 << size) - 1) << lane);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = op.sdata[8*(i % size) +: 8];
        e.res = 32'h0;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        v = (rdata >> (8*lane)) & mask;
        if (op.f3 < 4 && v[8*size-1]) v = v | ~mask;
        e.res = v;
      end
    end
    return e;
  endfunction

  // Issue one op and act as the memory: ready after rdy cycles, response rsp cycles after handshake.
  task automatic do_op(input op_t op, input int rdy, input int rsp, input logic [31:0] rdata,
                       input logic rerr, output obs_t ob);
    int hs;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    ob = '{default: 0};
    hs = -1; a0 = 0; w0 = 0; b0 = 0;
    tick();
    set_op(op); in_v_i = 1'b1;
    smp();
    ob.acc = in_ready_o;
    tick();
    in_v_i = 1'b0;
    for (int cyc = 1; cyc < 40 && !ob.done; cyc++) begin
      dmem_req_ready_i = (cyc - 1 >= rdy);
      dmem_resp_v_i    = ob.req && (cyc == hs + 1 + rsp);
      dmem_rdata_i     = rdata;
      dmem_resp_err_i  = rerr;
      smp();
      if (dmem_req_v_o) begin
        if (!ob.req && hs < 0 && a0 == 0 && b0 == 0 && w0 == 0) begin
          a0 = dmem_addr_o; b0 = dmem_be_o; w0 = dmem_wdata_o;
        end
        if (dmem_addr_o !== a0 || dmem_be_o !== b0 || dmem_wdata_o !== w0) ob.unstable = 1'b1;
        if (dmem_req_ready_i && !ob.req) begin
          ob.req = 1'b1; hs = cyc;
          ob.addr = dmem_addr_o; ob.be = dmem_be_o; ob.wdata = dmem_wdata_o; ob.we = dmem_we_o;
        end
      end
      if (out_v_o) begin
        ob.done = 1'b1; ob.lat = cyc; ob.res = out_result_o; ob.rdw = out_rd_w_v_o;
        ob.mis = out_misalign_o; ob.err = out_err_o; ob.rd = out_rd_o; ob.pay = out_payload_o;
      end
      tick();
    end
    dmem_req_ready_i = 1'b0;
    dmem_resp_v_i    = 1'b0;
  endtask

  task automatic check_op(input string tag, input op_t op, input obs_t ob, input exp_t e);
    chk({tag, ".accepted"}, 64'(ob.acc), 64'd1);
    chk({tag, ".out_v_seen"}, 64'(ob.done), 64'd1);
    if (ob.done) begin
      chk({tag, ".latency"}, 64'(ob.lat), 64'(e.lat));
      chk({tag, ".misalign"}, 64'(ob.mis), 64'(e.mis));
      chk({tag, ".rd_w_v"}, 64'(ob.rdw), 64'(e.rdw));
      chk({tag, ".rd"}, 64'(ob.rd), 64'(op.rd));
      chk({tag, ".payload"}, ob.pay, {op.addr, ~op.addr});
      if (!e.mis) begin
        chk({tag, ".result"}, 64'(ob.res), 64'(e.res));
        chk({tag, ".err"}, 64'(ob.err), 64'(e.err));
      end
    end
    chk({tag, ".req_issued"}, 64'(ob.req), 64'(e.req));
    if (e.req) begin
      chk({tag, ".req_addr"}, 64'(ob.addr), 64'(e.addr));
      chk({tag, ".req_we"}, 64'(ob.we), 64'(op.st));
      chk({tag, ".req_stable"}, 64'(ob.unstable), 64'd0);
      if (op.st) begin
        chk({tag, ".be"}, 64'(ob.be), 64'(e.be));
        chk({tag, ".wdata"}, 64'(ob.wdata), 64'(e.wdata));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t ob;
    exp_t e;
    op_t  op;
    logic [31:0] rd_data;
    int kind, rdy, rsp;
    logic rerr;

    // {ld,st,f3,addr,sdata,rd,rdw}, rdata, rerr, rdy, rsp, {res,rdw,mis,err,req,addr,be,wdata,lat}
    tbl[0]  = '{'{1'b0,1'b0,3'd0,32'h1234,32'h0,5'd5,1'b1}, 32'h0, 1'b0, 0, 0,
                '{32'h1234,1'b1,1'b0,1'b0,1'b0,32'h0,4'h0,32'h0,1}};
    tbl[1]  = '{'{1'b1,1'b0,3'd0,32'h103,32'h0,5'd6,1'b1}, 32'h80FF_0000, 1'b0, 0, 0,
                '{32'hFFFF_FF80,1'b1,1'b0,1'b0,1'b1,32'h100,4'h0,32'h0,3}};
    tbl[2]  = '{'{1'b1,1'b0,3'd4,32'h103,32'h0,5'd6,1'b1}, 32'h80FF_0000, 1'b0, 0, 0,
                '{32'h0000_0080,1'b1,1'b0,1'b0,1'b1,32'h100,4'h0,32'h0,3}};
    tbl[3]  = '{'{1'b0,1'b1,3'd1,32'h202,32'h0000_ABCD,5'd0,1'b0}, 32'h0, 1'b0, 0, 0,
                '{32'h0,1'b0,1'b0,1'b0,1'b1,32'h200,4'b1100,32'hABCD_ABCD,3}};
    tbl[4]  = '{'{1'b1,1'b0,3'd2,32'h101,32'h0,5'd8,1'b1}, 32'h0, 1'b0, 0, 0,
                '{32'h0,1'b0,1'b1,1'b0,1'b0,32'h0,4'h0,32'h0,1}};
    tbl[5]  = '{'{1'b1,1'b0,3'd1,32'h102,32'h0,5'd9,1'b1}, 32'h8001_0000, 1'b0, 2, 1,
                '{32'hFFFF_8001,1'b1,1'b0,1'b0,1'b1,32'h100,4'h0,32'h0,6}};
    tbl[6]  = '{'{1'b1,1'b0,3'd5,32'h102,32'h0,5'd9,1'b1}, 32'h8001_0000, 1'b0, 0, 0,
                '{32'h0000_8001,1'b1,1'b0,1'b0,1'b1,32'h100,4'h0,32'h0,3}};
    tbl[7]  = '{'{1'b1,1'b0,3'd2,32'h104,32'h0,5'd10,1'b1}, 32'hDEAD_BEEF, 1'b1, 4, 0,
                '{32'hDEAD_BEEF,1'b0,1'b0,1'b1,1'b1,32'h104,4'h0,32'h0,7}};
    tbl[8]  = '{'{1'b0,1'b1,3'd0,32'h001,32'h1234_5678,5'd0,1'b0}, 32'h0, 1'b0, 0, 0,
                '{32'h0,1'b0,1'b0,1'b0,1'b1,32'h0,4'b0010,32'h7878_7878,3}};
    tbl[9]  = '{'{1'b0,1'b1,3'd2,32'h008,32'hCAFE_F00D,5'd0,1'b0}, 32'h0, 1'b0, 1, 2,
                '{32'h0,1'b0,1'b0,1'b0,1'b1,32'h8,4'b1111,32'hCAFE_F00D,6}};
    tbl[10] = '{'{1'b0,1'b1,3'd1,32'h001,32'h5555,5'd0,1'b0}, 32'h0, 1'b0, 0, 0,
                '{32'h0,1'b0,1'b1,1'b0,1'b0,32'h0,4'h0,32'h0,1}};
    tbl[11] = '{'{1'b1,1'b0,3'd0,32'h100,32'h0,5'd11,1'b1}, 32'h0000_007F, 1'b0, 0, 0,
                '{32'h0000_007F,1'b1,1'b0,1'b0,1'b1,32'h100,4'h0,32'h0,3}};

    rst_i = 1'b0; flush_v_i = 0; stall_v_i = 0; in_v_i = 0;
    dmem_req_ready_i = 0; dmem_resp_v_i = 0; dmem_resp_err_i = 0; dmem_rdata_i = 0;
    set_op(mk(0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0));
    tick(); tick();
    smp();
    chk("rst.in_ready", 64'(in_ready_o), 64'd1);
    chk("rst.out_v", 64'(out_v_o), 64'd0);
    chk("rst.req_v", 64'(dmem_req_v_o), 64'd0);
    chk("rst.stall_v_o", 64'(stall_v_o), 64'd0);
    chk("rst.misalign", 64'(out_misalign_o), 64'd0);
    chk("rst.err", 64'(out_err_o), 64'd0);
    chk("rst.be", 64'(dmem_be_o), 64'd0);
    chk("rst.we", 64'(dmem_we_o), 64'd0);
    tick();
    rst_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].op, tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].rerr, ob);
      check_op($sformatf("tbl%0d", i), tbl[i].op, ob, tbl[i].e);
    end

    // Flush in WAIT; response arrives later and must be swallowed.
    tick(); set_op(mk(1, 0, 3'd2, 32'h40, 32'h0, 5'd4, 1'b1)); in_v_i = 1;
    smp(); chk("drain.accept", 64'(in_ready_o), 64'd1);
    tick(); in_v_i = 0; dmem_req_ready_i = 1;
    smp(); chk("drain.req_v", 64'(dmem_req_v_o), 64'd1);
    tick(); dmem_req_ready_i = 0; flush_v_i = 1;
    smp(); chk("drain.wait_out_v", 64'(out_v_o), 64'd0);
    tick(); flush_v_i = 0; set_op(mk(0, 0, 3'd0, 32'h99, 32'h0, 5'd12, 1'b1)); in_v_i = 1;
    smp(); chk("drain.in_ready1", 64'(in_ready_o), 64'd0);
    chk("drain.stall_v_o", 64'(stall_v_o), 64'd1);
    chk("drain.out_v1", 64'(out_v_o), 64'd0);
    tick();
    smp(); chk("drain.in_ready2", 64'(in_ready_o), 64'd0);
    tick(); dmem_resp_v_i = 1; dmem_rdata_i = 32'h1111_2222;
    smp(); chk("drain.in_ready3", 64'(in_ready_o), 64'd0);
    chk("drain.out_v3", 64'(out_v_o), 64'd0);
    tick(); dmem_resp_v_i = 0;
    smp(); chk("drain.in_ready_after", 64'(in_ready_o), 64'd1);
    chk("drain.out_v_after", 64'(out_v_o), 64'd0);
    tick(); in_v_i = 0;
    smp(); chk("drain.next_out_v", 64'(out_v_o), 64'd1);
    chk("drain.next_result", 64'(out_result_o), 64'h99);
    op = mk(1, 0, 3'd2, 32'h48, 32'h0, 5'd13, 1'b1);
    do_op(op, 0, 0, 32'h0BAD_F00D, 1'b0, ob);
    check_op("drain.next_load", op, ob, model(op, 32'h0BAD_F00D, 1'b0, 0, 0));

    // Flush in REQ with ready in the same cycle: request dropped.
    tick(); set_op(mk(1, 0, 3'd0, 32'h80, 32'h0, 5'd1, 1'b1)); in_v_i = 1;
    tick(); in_v_i = 0; dmem_req_ready_i = 1; flush_v_i = 1;
    smp(); chk("flushreq.req_v", 64'(dmem_req_v_o), 64'd0);
    tick(); dmem_req_ready_i = 0; flush_v_i = 0;
    smp(); chk("flushreq.in_ready", 64'(in_ready_o), 64'd1);
    chk("flushreq.req_v_after", 64'(dmem_req_v_o), 64'd0);
    tick();
    smp(); chk("flushreq.out_v", 64'(out_v_o), 64'd0);

    // Request backpressure, error response, then output stall.
    tick(); set_op(mk(1, 0, 3'd2, 32'h20, 32'h0, 5'd7, 1'b1)); in_v_i = 1;
    tick(); set_op(mk(0, 0, 3'd0, 32'h55, 32'h0, 5'd3, 1'b1));
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("rqstall%0d.req_v", k), 64'(dmem_req_v_o), 64'd1);
      chk($sformatf("rqstall%0d.addr", k), 64'(dmem_addr_o), 64'h20);
      chk($sformatf("rqstall%0d.be", k), 64'(dmem_be_o), 64'hF);
      chk($sformatf("rqstall%0d.stall_v_o", k), 64'(stall_v_o), 64'd1);
      tick();
    end
    dmem_req_ready_i = 1;
    smp(); chk("rqstall.hs_req_v", 64'(dmem_req_v_o), 64'd1);
    tick(); dmem_req_ready_i = 0; dmem_resp_v_i = 1; dmem_resp_err_i = 1;
    dmem_rdata_i = 32'h1122_3344; stall_v_i = 1;
    smp(); chk("rqstall.wait_out_v", 64'(out_v_o), 64'd0);
    tick(); dmem_resp_v_i = 0; dmem_resp_err_i = 0;
    smp(); chk("errresp.out_v", 64'(out_v_o), 64'd1);
    chk("errresp.err", 64'(out_err_o), 64'd1);
    chk("errresp.rd_w_v", 64'(out_rd_w_v_o), 64'd0);
    chk("errresp.rd", 64'(out_rd_o), 64'd7);
    chk("errresp.stall_v_o", 64'(stall_v_o), 64'd1);
    tick();
    smp(); chk("outhold.out_v", 64'(out_v_o), 64'd1);
    chk("outhold.err", 64'(out_err_o), 64'd1);
    chk("outhold.in_ready", 64'(in_ready_o), 64'd0);
    tick(); stall_v_i = 0;
    smp(); chk("release.in_ready", 64'(in_ready_o), 64'd1);
    tick(); in_v_i = 0; stall_v_i = 1;
    smp(); chk("release.out_v", 64'(out_v_o), 64'd1);
    chk("release.result", 64'(out_result_o), 64'h55);
    chk("release.err", 64'(out_err_o), 64'd0);
    tick();
    smp(); chk("hold2.out_v", 64'(out_v_o), 64'd1);
    chk("hold2.result", 64'(out_result_o), 64'h55);
    tick(); flush_v_i = 1;
    tick(); flush_v_i = 0; stall_v_i = 0;
    smp(); chk("flushhold.out_v", 64'(out_v_o), 64'd0);
    tick(); set_op(mk(0, 0, 3'd0, 32'h77, 32'h0, 5'd2, 1'b1)); in_v_i = 1; flush_v_i = 1;
    tick(); in_v_i = 0; flush_v_i = 0;
    smp(); chk("flush_no_accept.out_v", 64'(out_v_o), 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      op.ld = (kind == 1); op.st = (kind == 2);
      op.f3 = op.st ? 3'($urandom_range(0, 2)) : (op.ld ? ld_f3s[$urandom_range(0, 6)] : 3'($urandom));
      op.addr = $urandom; op.sdata = $urandom; op.rd = 5'($urandom);
      op.rdw = op.st ? 1'b0 : 1'($urandom);
      rd_data = $urandom; rerr = ($urandom_range(0, 7) == 0);
      rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
      e = model(op, rd_data, rerr, rdy, rsp);
      do_op(op, rdy, rsp, rd_data, rerr, ob);
      check_op($sformatf("rnd%0d", i), op, ob, e);
    end

    // Reset in the middle of an access abandons it.
    tick(); set_op(mk(1, 0, 3'd2, 32'h30, 32'h0, 5'd5, 1'b1)); in_v_i = 1;
    tick(); in_v_i = 0;
    smp(); chk("midrst.req_v_before", 64'(dmem_req_v_o), 64'd1);
    #1 rst_i = 0;
    #1 chk("midrst.req_v", 64'(dmem_req_v_o), 64'd0);
    chk("midrst.in_ready", 64'(in_ready_o), 64'd1);
    tick(); rst_i = 1;
    op = mk(0, 0, 3'd0, 32'hABCD, 32'h0, 5'd9, 1'b1);
    do_op(op, 0, 0, 32'h0, 1'b0, ob);
    check_op("midrst.after", op, ob, model(op, 32'h0, 1'b0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
